fir_reg_bank: RTL and testbench

FIR_REG_BANK -- requirements
Module: fir_reg_bank

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_coef_ram.sv | 51 +++++
 rtl/fir_reg_bank.sv | 177 +++++++++++++++++
 tb/tb_fir_reg_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR register bank.
//   - Register map addresses (CTRL, STATUS, NUM_TAPS, ID, coefficient window)
//   - Bit positions inside CTRL and STATUS
//   - ID value, default coefficient count, index/tap-count widths
//   - Register-select enumeration used by the address decoder
package fir_pkg;

  localparam int N_COEF_DEF = 32;
  localparam int COEF_IDX_W = 5;
  localparam int TAPS_W     = 6;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_STATUS   = 6'h01;
  localparam logic [5:0] ADDR_NUM_TAPS = 6'h02;
  localparam logic [5:0] ADDR_ID       = 6'h03;
  localparam logic [5:0] COEF_BASE     = 6'h20;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

  localparam logic [15:0] ID_VALUE = 16'hF1A0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_TAPS,
    SEL_ID,
    SEL_COEF,
    SEL_NONE
  } reg_sel_e;

endpackage

// File: rtl/fir_coef_ram.sv
// Coefficient storage: one write port, two synchronous read ports.
//   clk_i      block clock
//   rst_i      synchronous active-high reset, clears every entry and both outputs
//   we_i       write enable
//   waddr_i    write index
//   wdata_i    write data
//   raddr_a_i  read-back index (register interface side)
//   rdata_a_o  read-back data, write-first: a same-cycle write is returned
//   raddr_b_i  read index (FIR core side)
//   rdata_b_o  FIR data, read-first: a same-cycle write returns the old value
module fir_coef_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // Read-back reports the value as stored, so bypass a colliding write.
      rdata_a_q <= (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/fir_reg_bank.sv
// Register bank between the CDC write/read port and the FIR core.
//   clk_b       block clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   CDC_A       register address from the CDC module
//   CDC_data    write data from the CDC module
//   CDC_wr      write strobe, may be held for several cycles per transfer
//   data_back   registered read-back of the register at CDC_A
//   fir_enable  CTRL.ENABLE
//   fir_start   one-cycle start pulse to the FIR core
//   fir_busy    FIR core busy level
//   fir_done    FIR core completion pulse
//   num_taps    active tap count, 1..N_COEF
//   coef_idx    coefficient index requested by the FIR core
//   coef_out    registered coefficient at coef_idx
module fir_reg_bank
  import fir_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int N_COEF = N_COEF_DEF
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     CDC_A,
  input  logic [DATA_W-1:0]     CDC_data,
  input  logic                  CDC_wr,
  output logic [DATA_W-1:0]     data_back,
  output logic                  fir_enable,
  output logic                  fir_start,
  input  logic                  fir_busy,
  input  logic                  fir_done,
  output logic [TAPS_W-1:0]     num_taps,
  input  logic [COEF_IDX_W-1:0] coef_idx,
  output logic [DATA_W-1:0]     coef_out
);

  // Zero becomes 1, anything above N_COEF clamps to N_COEF.
  function automatic logic [TAPS_W-1:0] sat_taps(input logic [DATA_W-1:0] v);
    if (v == '0) begin
      return TAPS_W'(1);
    end else if (v > DATA_W'(N_COEF)) begin
      return TAPS_W'(N_COEF);
    end else begin
      return v[TAPS_W-1:0];
    end
  endfunction

  reg_sel_e                sel;
  logic [ADDR_W-1:0]       coef_off;
  logic [COEF_IDX_W-1:0]   coef_addr;
  logic                    commit;
  logic                    coef_we;

  logic                    wr_prev_q;
  // Set when reset sees the strobe high; holds off commits until the strobe drops.
  logic                    wr_block_q;

  logic                    enable_q, enable_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    start_q, start_d;
  logic                    start_err, done_clr, err_clr;
  logic [TAPS_W-1:0]       taps_q, taps_d;
  logic [DATA_W-1:0]       rd_q, rd_d;
  logic                    sel_coef_q;
  logic [DATA_W-1:0]       ram_rd_a;

  always_comb begin
    coef_off = CDC_A - ADDR_W'(COEF_BASE);
    sel      = SEL_NONE;
    if (CDC_A == ADDR_W'(ADDR_CTRL)) begin
      sel = SEL_CTRL;
    end else if (CDC_A == ADDR_W'(ADDR_STATUS)) begin
      sel = SEL_STATUS;
    end else if (CDC_A == ADDR_W'(ADDR_NUM_TAPS)) begin
      sel = SEL_TAPS;
    end else if (CDC_A == ADDR_W'(ADDR_ID)) begin
      sel = SEL_ID;
    end else if ((CDC_A >= ADDR_W'(COEF_BASE)) && (coef_off < ADDR_W'(N_COEF))) begin
      sel = SEL_COEF;
    end
  end

  assign coef_addr = COEF_IDX_W'(coef_off);
  assign commit    = CDC_wr & ~wr_prev_q & ~wr_block_q;
  assign coef_we   = commit & (sel == SEL_COEF);

  always_comb begin
    enable_d  = enable_q;
    taps_d    = taps_q;
    start_d   = 1'b0;
    start_err = 1'b0;
    done_clr  = 1'b0;
    err_clr   = 1'b0;
    if (commit) begin
      case (sel)
        SEL_CTRL: begin
          enable_d = CDC_data[CTRL_ENABLE_BIT];
          if (CDC_data[CTRL_START_BIT]) begin
            start_d   = ~fir_busy;
            start_err = fir_busy;
          end
        end
        SEL_STATUS: begin
          done_clr = CDC_data[STAT_DONE_BIT];
          err_clr  = CDC_data[STAT_ERR_BIT];
        end
        SEL_TAPS: taps_d = sat_taps(CDC_data);
        default: ;
      endcase
    end
    // Set events win over a simultaneous W1C clear.
    done_d = (done_q & ~done_clr) | fir_done;
    err_d  = (err_q & ~err_clr) | start_err;

    // Read-back is taken from next-state values so a commit returns what is stored.
    rd_d = '0;
    case (sel)
      SEL_CTRL:   rd_d[CTRL_ENABLE_BIT] = enable_d;
      SEL_STATUS: begin
        rd_d[STAT_BUSY_BIT] = fir_busy;
        rd_d[STAT_DONE_BIT] = done_d;
        rd_d[STAT_ERR_BIT]  = err_d;
      end
      SEL_TAPS:   rd_d = DATA_W'(taps_d);
      SEL_ID:     rd_d = DATA_W'(ID_VALUE);
      default:    rd_d = '0;
    endcase
  end

  // ---- register stage: control state and read-back ----
  always_ff @(posedge clk_b) begin
    if (rst) begin
      wr_prev_q  <= 1'b0;
      wr_block_q <= CDC_wr;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      taps_q     <= TAPS_W'(N_COEF);
      rd_q       <= '0;
      sel_coef_q <= 1'b0;
    end else begin
      wr_prev_q  <= CDC_wr;
      wr_block_q <= wr_block_q & CDC_wr;
      enable_q   <= enable_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      taps_q     <= taps_d;
      rd_q       <= rd_d;
      sel_coef_q <= (sel == SEL_COEF);
    end
  end

  fir_coef_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (N_COEF),
    .IDX_W  (COEF_IDX_W)
  ) u_coef_ram (
    .clk_i     (clk_b),
    .rst_i     (rst),
    .we_i      (coef_we),
    .waddr_i   (coef_addr),
    .wdata_i   (CDC_data),
    .raddr_a_i (coef_addr),
    .rdata_a_o (ram_rd_a),
    .raddr_b_i (coef_idx),
    .rdata_b_o (coef_out)
  );

  assign data_back  = sel_coef_q ? ram_rd_a : rd_q;
  assign fir_enable = enable_q;
  assign fir_start  = start_q;
  assign num_taps   = taps_q;

endmodule

// File: tb/tb_fir_reg_bank.sv
module tb_fir_reg_bank;

  logic        clk_b = 1'b0;
  logic        rst;
  logic [5:0]  CDC_A;
  logic [15:0] CDC_data;
  logic        CDC_wr;
  logic [15:0] data_back;
  logic        fir_enable;
  logic        fir_start;
  logic        fir_busy;
  logic        fir_done;
  logic [5:0]  num_taps;
  logic [4:0]  coef_idx;
  logic [15:0] coef_out;

  int checks = 0;
  int errors = 0;

  // Reference state of the register map
  logic [15:0] m_coef [32];
  logic        m_enable, m_done, m_err;
  logic [5:0]  m_taps;

  fir_reg_bank dut (
    .clk_b      (clk_b),
    .rst        (rst),
    .CDC_A      (CDC_A),
    .CDC_data   (CDC_data),
    .CDC_wr     (CDC_wr),
    .data_back  (data_back),
    .fir_enable (fir_enable),
    .fir_start  (fir_start),
    .fir_busy   (fir_busy),
    .fir_done   (fir_done),
    .num_taps   (num_taps),
    .coef_idx   (coef_idx),
    .coef_out   (coef_out)
  );

  always #5 clk_b = ~clk_b;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_coef[i] = 16'h0000;
    m_enable = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_taps   = 6'd32;
  endtask

  function automatic logic [15:0] model_read(input logic [5:0] a, input logic busy);
    logic [15:0] r;
    r = 16'h0000;
    if (a == 6'h00)      r = {15'd0, m_enable};
    else if (a == 6'h01) r = {13'd0, m_err, m_done, busy};
    else if (a == 6'h02) r = {10'd0, m_taps};
    else if (a == 6'h03) r = 16'hF1A0;
    else if (a >= 6'h20) r = m_coef[a - 6'h20];
    return r;
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [15:0] d, input logic busy,
                             input logic done, output logic start);
    start = 1'b0;
    if (a == 6'h00) begin
      m_enable = d[0];
      if (d[1]) begin
        if (busy) m_err = 1'b1;
        else      start = 1'b1;
      end
    end else if (a == 6'h01) begin
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_err  = 1'b0;
    end else if (a == 6'h02) begin
      if (d == 16'd0)      m_taps = 6'd1;
      else if (d > 16'd32) m_taps = 6'd32;
      else                 m_taps = 6'(d);
    end else if (a >= 6'h20) begin
      m_coef[a - 6'h20] = d;
    end
    if (done) m_done = 1'b1;
  endtask

  // One strobe of 'hold' high cycles, then one low cycle.
  task automatic do_write(input logic [5:0] a, input logic [15:0] d, input int hold,
                          input logic busy, input logic done);
    logic [15:0] exp_co;
    logic        exp_start;
    fir_busy = busy;
    fir_done = done;
    CDC_A    = a;
    CDC_data = d;
    CDC_wr   = 1'b1;
    exp_co   = m_coef[coef_idx];
    model_write(a, d, busy, done, exp_start);
    tick();
    fir_done = 1'b0;
    chk("wr_readback", data_back, model_read(a, busy));
    chk("wr_start", fir_start, exp_start);
    chk("wr_coef_old", coef_out, exp_co);
    chk("wr_enable", fir_enable, m_enable);
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) CDC_wr = 1'b0;
      tick();
      chk("hold_start", fir_start, 1'b0);
      chk("hold_readback", data_back, model_read(a, busy));
      chk("hold_taps", num_taps, m_taps);
    end
  endtask

  task automatic do_read(input logic [5:0] a, input logic [4:0] k);
    CDC_A    = a;
    coef_idx = k;
    tick();
    chk("rd_data", data_back, model_read(a, fir_busy));
    chk("rd_coef", coef_out, m_coef[k]);
    chk("rd_taps", num_taps, m_taps);
  endtask

  initial begin
    logic [5:0]  ra;
    logic [15:0] rd;
    int          pick;

    rst = 1'b1; CDC_A = 6'h00; CDC_data = 16'h0000; CDC_wr = 1'b0;
    fir_busy = 1'b0; fir_done = 1'b0; coef_idx = 5'd0;
    model_reset();
    tick();
    tick();
    chk("rst_data_back", data_back, 16'h0000);
    chk("rst_coef_out", coef_out, 16'h0000);
    chk("rst_start", fir_start, 1'b0);
    chk("rst_enable", fir_enable, 1'b0);
    chk("rst_taps", num_taps, 6'd32);
    rst = 1'b0;

    // ID and default tap count
    do_read(6'h03, 5'd0);
    chk("id_value", data_back, 16'hF1A0);
    do_read(6'h02, 5'd0);
    chk("taps_default", data_back, 16'd32);

    // Held strobe commits once; same-cycle FIR read sees the old value
    coef_idx = 5'd5;
    do_write(6'h25, 16'hABCD, 4, 1'b0, 1'b0);
    do_read(6'h25, 5'd5);
    chk("coef5_out", coef_out, 16'hABCD);
    chk("coef5_rd", data_back, 16'hABCD);

    // Tap count saturation
    do_write(6'h02, 16'd0, 1, 1'b0, 1'b0);
    do_read(6'h02, 5'd0);
    chk("taps_zero", data_back, 16'd1);
    do_write(6'h02, 16'd40, 2, 1'b0, 1'b0);
    do_read(6'h02, 5'd0);
    chk("taps_sat", data_back, 16'd32);
    chk("taps_port", num_taps, 6'd32);

    // START with idle core, then with busy core
    do_write(6'h00, 16'h0003, 1, 1'b0, 1'b0);
    chk("enable_set", fir_enable, 1'b1);
    do_write(6'h00, 16'h0003, 3, 1'b1, 1'b0);
    do_read(6'h01, 5'd0);
    chk("status_err", data_back, 16'h0005);

    // DONE set beats a simultaneous clear, later cleared together with ERR
    do_write(6'h01, 16'h0002, 1, 1'b1, 1'b1);
    do_read(6'h01, 5'd0);
    chk("done_sticky", data_back, 16'h0007);
    fir_busy = 1'b0;
    do_write(6'h01, 16'h0006, 1, 1'b0, 1'b0);
    do_read(6'h01, 5'd0);
    chk("status_clear", data_back, 16'h0000);

    // Reset right after a start commit kills the pulse
    CDC_A = 6'h00; CDC_data = 16'h0002; CDC_wr = 1'b1; fir_busy = 1'b0;
    tick();
    chk("start_pulse", fir_start, 1'b1);
    rst = 1'b1; CDC_wr = 1'b0;
    tick();
    chk("start_killed", fir_start, 1'b0);
    rst = 1'b0;
    model_reset();
    tick();

    // Reset mid-strobe; strobe still high afterwards must not commit
    CDC_A = 6'h20; CDC_data = 16'h1234; CDC_wr = 1'b1; coef_idx = 5'd0;
    tick();
    chk("coef0_commit", data_back, 16'h1234);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    CDC_data = 16'h5555;
    tick();
    tick();
    chk("no_commit_after_rst", data_back, 16'h0000);
    CDC_wr = 1'b0;
    tick();
    do_read(6'h20, 5'd0);
    chk("coef0_cleared", coef_out, 16'h0000);

    // Randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       ra = 6'h00;
        1:       ra = 6'h01;
        2, 3:    ra = 6'h02;
        4:       ra = 6'h03;
        5:       ra = 6'($urandom_range(4, 31));
        default: ra = 6'($urandom_range(32, 63));
      endcase
      rd = 16'($urandom);
      if (ra == 6'h02) begin
        case ($urandom_range(0, 2))
          0:       rd = 16'd0;
          1:       rd = 16'($urandom_range(1, 32));
          default: rd = 16'($urandom_range(33, 65535));
        endcase
      end
      coef_idx = 5'($urandom);
      do_write(ra, rd, int'($urandom_range(1, 3)), 1'($urandom), ($urandom_range(0, 3) == 0));
      fir_busy = 1'($urandom);
      do_read(6'($urandom), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
